fetch_ctrl: RTL

- Instruction-fetch sequencer for the out-of-order core.
- Owns the PC and drives the address of the combinational-read instruction cache.
- Buffers fetched {pc, instruction} pairs in a small FIFO and delivers them to decode over a valid/ready handshake.
- Handles back-end redirects (branch mispredict or flush) and stops fetching past the end of instruction memory.

---
 rtl/fetch_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer. Owns the PC, drives the address of a
//   combinational-read instruction cache, queues {pc, instr} pairs in a small
//   FIFO and hands them to decode over a valid/ready handshake. Back-end
//   redirects flush the queue and restart fetch; fetch stops once the PC
//   reaches the end of instruction memory (MEM_WORDS*4).
//
//   Optional build macro: FETCH_PERF_CNT_EN adds three 32-bit performance
//   counters (perf_fetched, perf_full_stalls, perf_redirects).
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   icache_addr    out  byte address to the instruction cache (current PC)
//   icache_instr   in   instruction returned combinationally for icache_addr
//   dec_valid      out  head entry valid toward decode
//   dec_ready      in   decode accepts the head entry
//   dec_instr      out  head instruction (0 when empty)
//   dec_pc         out  head PC (0 when empty)
//   redirect_valid in   flush queue and restart fetch at redirect_pc
//   redirect_pc    in   restart byte address (low two bits ignored)
//   halted         out  fetch stopped at end of memory
//   fifo_count     out  occupied queue entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 552
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [31:0]              icache_addr,
  input  logic [31:0]              icache_instr,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_instr,
  output logic [31:0]              dec_pc,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_full_stalls,
  output logic [31:0]              perf_redirects
`endif
);

  localparam int          PW       = $clog2(DEPTH);
  localparam int          CW       = PW + 1;
  localparam logic [31:0] END_ADDR = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t          r_state;
  logic [31:0]     r_pc;
  logic            r_halted;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_pc_mem    [DEPTH];
  logic [31:0]     r_instr_mem [DEPTH];

  logic            w_at_end;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic [31:0]     w_redirect_pc;

  assign w_at_end      = (r_pc >= END_ADDR);
  assign w_full        = (r_count == CW'(DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_redirect_pc = redirect_pc & ~32'h3;

  // A redirect hides the head from decode so nothing is consumed in the
  // cycle that flushes the queue.
  assign dec_valid = !w_empty && !redirect_valid;
  assign w_pop     = dec_valid && dec_ready;

  // A full queue can still accept a new entry when the head leaves this cycle.
  assign w_push = (r_state == S_FETCH) && !redirect_valid && !w_at_end &&
                  (!w_full || w_pop);

  assign icache_addr = r_pc;
  assign dec_pc      = w_empty ? 32'h0 : r_pc_mem[r_rd_ptr];
  assign dec_instr   = w_empty ? 32'h0 : r_instr_mem[r_rd_ptr];
  assign halted      = r_halted;
  assign fifo_count  = r_count;

  // Sequencer FSM plus queue bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_state  <= S_FETCH;
      r_pc     <= w_redirect_pc;
      r_halted <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: begin
          if (w_at_end) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        default: r_halted <= 1'b1;
      endcase

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_pc;
      r_instr_mem[r_wr_ptr] <= icache_instr;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic w_full_stall;

  assign w_full_stall = (r_state == S_FETCH) && !redirect_valid && !w_at_end &&
                        w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched     <= '0;
      perf_full_stalls <= '0;
      perf_redirects   <= '0;
    end else begin
      if (w_push)         perf_fetched     <= perf_fetched + 32'd1;
      if (w_full_stall)   perf_full_stalls <= perf_full_stalls + 32'd1;
      if (redirect_valid) perf_redirects   <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule
